// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin frame-buffer write arbiter with (x,y)->address mapping and vsync buffer flip.
// Optional build macro FB_ARB_STATS_EN adds drop_cnt, a saturating count of off-screen beats.
module fb_write_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int PIX_W     = 5,
    parameter int ADDR_W    = 19,
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int MAX_BURST = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     VS,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*10-1:0]    wr_x,
    input  logic [NUM_REQ*10-1:0]    wr_y,
    input  logic [NUM_REQ*PIX_W-1:0] wr_pix,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     fb_we,
    output logic [ADDR_W-1:0]        fb_addr,
    output logic [PIX_W-1:0]         fb_data,
    output logic                     back_sel,
    output logic                     frame_start
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]              drop_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SWAP  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   w_gnt_nxt;
    logic [IDX_W-1:0]     r_gnt_idx;
    logic [IDX_W-1:0]     w_gnt_idx_nxt;
    logic [IDX_W-1:0]     r_last_winner;
    logic [IDX_W-1:0]     w_last_nxt;
    logic [CNT_W-1:0]     r_beat_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic                 r_swap_pend;
    logic                 w_swap_pend_nxt;
    logic                 w_swap_req;
    logic                 r_vs_meta;
    logic                 r_vs_sync;
    logic                 r_vs_prev;
    logic                 w_vs_fall;
    logic                 r_back_sel;
    logic                 w_back_sel_nxt;
    logic                 r_frame_start;
    logic                 w_frame_start_nxt;
    logic                 r_fb_we;
    logic [ADDR_W-1:0]    r_fb_addr;
    logic [PIX_W-1:0]     r_fb_data;
    logic [IDX_W-1:0]     w_win_idx;
    logic [IDX_W-1:0]     w_cand;
    logic [9:0]           w_sel_x;
    logic [9:0]           w_sel_y;
    logic [PIX_W-1:0]     w_sel_pix;
    logic                 w_onscreen;
    logic [ADDR_W-1:0]    w_addr;
    logic [NUM_REQ-1:0]   w_ack;
    logic                 w_ack_any;
    logic                 w_req_cur;

    // VS is asynchronous and active-low: two-flop synchroniser plus falling-edge history flop
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_vs_meta <= 1'b1;
            r_vs_sync <= 1'b1;
            r_vs_prev <= 1'b1;
        end else begin
            r_vs_meta <= VS;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
        end
    end

    assign w_vs_fall  = r_vs_prev & ~r_vs_sync;
    assign w_swap_req = r_swap_pend | w_vs_fall;
    // Edges seen during the SWAP cycle belong to the flip being performed and are absorbed
    assign w_swap_pend_nxt = (r_state == ST_SWAP) ? 1'b0 : w_swap_req;

    assign w_ack     = (r_state == ST_GRANT) ? (r_gnt & req) : {NUM_REQ{1'b0}};
    assign w_ack_any = |w_ack;
    assign w_req_cur = req[r_gnt_idx];
    assign w_cnt_inc = w_ack_any ? (r_beat_cnt + CNT_W'(1)) : r_beat_cnt;

    // Round-robin winner: lowest offset above last_winner with an active request (scan runs high to low)
    always_comb begin
        w_win_idx = r_last_winner;
        w_cand    = r_last_winner;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand    = IDX_W'((int'(r_last_winner) + k) % NUM_REQ);
            w_win_idx = req[w_cand] ? w_cand : w_win_idx;
        end
    end

    // Beat mux for the currently granted requester
    always_comb begin
        w_sel_x   = 10'd0;
        w_sel_y   = 10'd0;
        w_sel_pix = {PIX_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sel_x   = (r_gnt_idx == IDX_W'(k)) ? wr_x[10*k +: 10]         : w_sel_x;
            w_sel_y   = (r_gnt_idx == IDX_W'(k)) ? wr_y[10*k +: 10]         : w_sel_y;
            w_sel_pix = (r_gnt_idx == IDX_W'(k)) ? wr_pix[PIX_W*k +: PIX_W] : w_sel_pix;
        end
    end

    assign w_onscreen = (int'(w_sel_x) < H_RES) && (int'(w_sel_y) < V_RES);
    assign w_addr     = ADDR_W'(w_sel_y) * ADDR_W'(H_RES) + ADDR_W'(w_sel_x);

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and next values of the registered control outputs
    always_comb begin
        w_state_nxt       = r_state;
        w_gnt_nxt         = r_gnt;
        w_gnt_idx_nxt     = r_gnt_idx;
        w_last_nxt        = r_last_winner;
        w_cnt_nxt         = r_beat_cnt;
        w_back_sel_nxt    = r_back_sel;
        w_frame_start_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_swap_req) begin
                    w_state_nxt       = ST_SWAP;
                    w_back_sel_nxt    = ~r_back_sel;
                    w_frame_start_nxt = 1'b1;
                end else if (|req) begin
                    w_state_nxt   = ST_GRANT;
                    w_gnt_nxt     = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win_idx;
                    w_gnt_idx_nxt = w_win_idx;
                    w_cnt_nxt     = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                w_cnt_nxt = w_cnt_inc;
                // The beat acked in this cycle still completes; the grant drops on the next edge
                if (!w_req_cur || (w_cnt_inc == CNT_W'(MAX_BURST)) || w_swap_req) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = {NUM_REQ{1'b0}};
                    w_last_nxt  = r_gnt_idx;
                end else begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_SWAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = {NUM_REQ{1'b0}};
            end
        endcase
    end

    // Control registers driven by the FSM
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_gnt         <= {NUM_REQ{1'b0}};
            r_gnt_idx     <= {IDX_W{1'b0}};
            r_last_winner <= IDX_W'(NUM_REQ - 1);
            r_beat_cnt    <= {CNT_W{1'b0}};
            r_swap_pend   <= 1'b0;
            r_back_sel    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_gnt         <= w_gnt_nxt;
            r_gnt_idx     <= w_gnt_idx_nxt;
            r_last_winner <= w_last_nxt;
            r_beat_cnt    <= w_cnt_nxt;
            r_swap_pend   <= w_swap_pend_nxt;
            r_back_sel    <= w_back_sel_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

    // Write datapath: one-cycle latency, address and data hold while no write is issued
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fb_we   <= 1'b0;
            r_fb_addr <= {ADDR_W{1'b0}};
            r_fb_data <= {PIX_W{1'b0}};
        end else if (w_ack_any && w_onscreen) begin
            r_fb_we   <= 1'b1;
            r_fb_addr <= w_addr;
            r_fb_data <= w_sel_pix;
        end else begin
            r_fb_we   <= 1'b0;
        end
    end

`ifdef FB_ARB_STATS_EN
    logic [15:0] r_drop_cnt;

    // Saturating off-screen beat counter, restarted each frame
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_drop_cnt <= 16'd0;
        end else if (r_state == ST_SWAP) begin
            r_drop_cnt <= 16'd0;
        end else if (w_ack_any && !w_onscreen && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end else begin
            r_drop_cnt <= r_drop_cnt;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign gnt         = r_gnt;
    assign ack         = w_ack;
    assign fb_we       = r_fb_we;
    assign fb_addr     = r_fb_addr;
    assign fb_data     = r_fb_data;
    assign back_sel    = r_back_sel;
    assign frame_start = r_frame_start;

endmodule
